chunked_adder_acc: RTL and testbench

//  Multi-cycle, parametrised ripple-carry adder/subtractor with an accumulator.

---
 rtl/chunked_adder_acc.sv | 133 +++++++++++++
 tb/tb_chunked_adder_acc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder_acc.sv
`default_nettype none
// ============================================================================
// Module   : chunked_adder_acc
// Brief    : Multi-cycle ripple-carry adder/subtractor with accumulator,
//            CHUNK bits per clock, lowest chunk first.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_adder_acc #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] acc
);

  localparam int c_NCH = WIDTH / CHUNK;
  localparam int c_KW  = (c_NCH > 1) ? $clog2(c_NCH) : 1;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_RUN  = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  localparam logic [1:0] c_M_ADD = 2'b00;
  localparam logic [1:0] c_M_SUB = 2'b01;
  localparam logic [1:0] c_M_ACC = 2'b10;
  localparam logic [1:0] c_M_CLR = 2'b11;

  localparam logic [c_KW-1:0] c_K_LAST = c_KW'(c_NCH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_carry;
  logic             r_is_acc;
  logic [c_KW-1:0]  r_k;
  logic [WIDTH-1:0] r_part;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK:0]   w_cs;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_part_next;

  // Operands shift right one chunk per cycle, so the active chunk is always the LSBs.
  assign w_ca = r_opa[CHUNK-1:0];
  assign w_cb = r_opb[CHUNK-1:0];
  assign w_cs = {1'b0, w_ca} + {1'b0, w_cb} + {{CHUNK{1'b0}}, r_carry};

  // Carry into the top bit of this chunk, recovered from the sum bit and its operands.
  assign w_cmsb = w_cs[CHUNK-1] ^ w_ca[CHUNK-1] ^ w_cb[CHUNK-1];

  generate
    if (c_NCH == 1) begin : g_part_single
      assign w_part_next = w_cs[CHUNK-1:0];
    end else begin : g_part_shift
      assign w_part_next = {w_cs[CHUNK-1:0], r_part[WIDTH-1:CHUNK]};
    end
  endgenerate

  assign in_ready = (r_state == c_S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_S_IDLE;
      r_opa     <= '0;
      r_opb     <= '0;
      r_carry   <= 1'b0;
      r_is_acc  <= 1'b0;
      r_k       <= '0;
      r_part    <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (in_valid) begin
            if (mode == c_M_CLR) begin
              acc <= '0;
            end else begin
              r_opa    <= a;
              r_opb    <= (mode == c_M_SUB) ? ~b : ((mode == c_M_ACC) ? acc : b);
              r_carry  <= (mode == c_M_SUB) ? 1'b1 : cin;
              r_is_acc <= (mode == c_M_ACC);
              r_k      <= '0;
              r_part   <= '0;
              r_state  <= c_S_RUN;
            end
          end
        end
        c_S_RUN: begin
          r_opa   <= r_opa >> CHUNK;
          r_opb   <= r_opb >> CHUNK;
          r_carry <= w_cs[CHUNK];
          r_part  <= w_part_next;
          r_k     <= r_k + c_KW'(1);
          if (r_k == c_K_LAST) begin
            sum       <= w_part_next;
            cout      <= w_cs[CHUNK];
            ovf       <= w_cmsb ^ w_cs[CHUNK];
            out_valid <= 1'b1;
            r_state   <= c_S_DONE;
            if (r_is_acc) begin
              acc <= w_part_next;
            end
          end
        end
        c_S_DONE: begin
          r_state <= c_S_IDLE;
        end
        default: begin
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_adder_acc
// Brief    : Self-checking bench for chunked_adder_acc against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_adder_acc;

  localparam int W   = 12;
  localparam int CH  = 3;
  localparam int NCH = W / CH;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a        = '0;
  logic [W-1:0] b        = '0;
  logic         cin      = 1'b0;
  logic [1:0]   mode     = 2'b00;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [W-1:0] acc;

  int n_checks = 0;
  int n_fails  = 0;

  logic [W-1:0] m_acc  = '0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;

  chunked_adder_acc #(.WIDTH(W), .CHUNK(CH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .mode      (mode),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic model_op(input logic [1:0] m, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc);
    logic [W-1:0] opnd;
    longint       ua;
    int           ia;
    int           ib;
    int           r;
    if (m == 2'b11) begin
      m_acc = '0;
      return;
    end
    opnd = (m == 2'b10) ? m_acc : tb_;
    ia   = int'($signed(ta));
    ib   = int'($signed(opnd));
    if (m == 2'b01) begin
      m_sum  = ta - tb_;
      m_cout = (ta >= tb_);
      r      = ia - ib;
    end else begin
      ua     = longint'(ta) + longint'(opnd) + longint'(tc);
      m_sum  = W'(ua);
      m_cout = (ua >= (longint'(1) << W));
      r      = ia + ib + int'(tc);
    end
    m_ovf = (r < -(1 << (W - 1))) || (r > ((1 << (W - 1)) - 1));
    if (m == 2'b10) m_acc = m_sum;
  endtask

  // Called just after the accept edge (+1); waits for the result pulse.
  task automatic wait_result(input string tag);
    int cyc = 0;
    while (out_valid !== 1'b1 && cyc < 4 * NCH) begin
      check($sformatf("%s.busy_rdy", tag), in_ready, 0);
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("%s.latency", tag), cyc, NCH);
    check($sformatf("%s.done_rdy", tag), in_ready, 0);
    check($sformatf("%s.sum", tag), sum, m_sum);
    check($sformatf("%s.cout", tag), cout, m_cout);
    check($sformatf("%s.ovf", tag), ovf, m_ovf);
    check($sformatf("%s.acc", tag), acc, m_acc);
    @(posedge clk); #1;
    check($sformatf("%s.pulse_end", tag), out_valid, 0);
    check($sformatf("%s.idle_rdy", tag), in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] m, input logic [W-1:0] ta,
                        input logic [W-1:0] tb_, input logic tc);
    check($sformatf("%s.start_rdy", tag), in_ready, 1);
    in_valid = 1'b1;
    mode     = m;
    a        = ta;
    b        = tb_;
    cin      = tc;
    model_op(m, ta, tb_, tc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    mode     = 2'($urandom_range(0, 3));
    cin      = 1'($urandom_range(0, 1));
    if (m == 2'b11) begin
      check($sformatf("%s.clr_acc", tag), acc, m_acc);
      check($sformatf("%s.clr_rdy", tag), in_ready, 1);
      check($sformatf("%s.clr_nov", tag), out_valid, 0);
      check($sformatf("%s.clr_sum", tag), sum, m_sum);
    end else begin
      wait_result(tag);
    end
  endtask

  initial begin
    logic saw_valid;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst.sum", sum, 0);
    check("rst.acc", acc, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.cout", cout, 0);
    check("rst.ovf", ovf, 0);

    run_op("add_wrap", 2'b00, 12'hFFF, 12'h001, 1'b0);
    run_op("sub_neg", 2'b01, 12'h005, 12'h007, 1'b0);
    run_op("add_ovf", 2'b00, 12'h7FF, 12'h001, 1'b0);
    run_op("acc_pre", 2'b10, 12'h0AB, 12'h000, 1'b1);
    run_op("clr", 2'b11, 12'h000, 12'h000, 1'b0);
    for (int i = 0; i < 3; i++) run_op($sformatf("acc%0d", i), 2'b10, 12'h100, 12'h5A5, 1'b0);
    check("acc3.final", acc, 12'h300);
    check("acc3.sum", sum, 12'h300);

    // Abort an ADD after two RUN cycles.
    in_valid = 1'b1;
    mode     = 2'b00;
    a        = 12'h123;
    b        = 12'h456;
    cin      = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    saw_valid = out_valid;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_acc = '0;
    m_sum = '0;
    m_cout = 1'b0;
    m_ovf = 1'b0;
    check("abort.sum", sum, 0);
    check("abort.acc", acc, 0);
    check("abort.cout", cout, 0);
    check("abort.ovf", ovf, 0);
    check("abort.rdy", in_ready, 1);
    for (int i = 0; i < NCH + 2; i++) begin
      if (out_valid === 1'b1) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("abort.no_valid", saw_valid, 0);

    // Busy: in_valid held high through RUN with new operands.
    in_valid = 1'b1;
    mode     = 2'b00;
    a        = 12'h3C1;
    b        = 12'h0F7;
    cin      = 1'b0;
    model_op(2'b00, 12'h3C1, 12'h0F7, 1'b0);
    @(posedge clk); #1;
    a        = 12'h6D2;
    b        = 12'h2A9;
    cin      = 1'b1;
    wait_result("busy1");
    model_op(2'b00, 12'h6D2, 12'h2A9, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("busy2");

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
